imem_fetch_arbiter: RTL and testbench

Sequencer and arbiter for the byte-wide instruction memory. It shares the memory's single port between the pipeline's IF stage, which reads 32-bit instructions, and the program loader, which writes bytes. It reads four little-endian bytes over four cycles and presents one assembled instruction to IF/ID with a valid/ready handshake. It sits between the IF-stage PC logic and the instruction memory array, which has a combinational read and a synchronous byte write.

---
 rtl/imem_fetch_arbiter_if.sv | 36 +++
 rtl/imem_fetch_arbiter.sv | 152 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of the IF-stage fetch handshake, program-loader handshake and byte-wide
// instruction-memory port seen by imem_fetch_arbiter.
interface imem_fetch_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic [31:0]       fetch_pc_out;
    logic              fetch_ready;
    logic              flush;
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_addr;
    logic [7:0]        ld_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  fetch_req, fetch_pc, fetch_ready, flush,
        input  ld_valid, ld_addr, ld_data, mem_rdata,
        output fetch_valid, fetch_instr, fetch_pc_out, ld_ready,
        output mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output fetch_req, fetch_pc, fetch_ready, flush,
        output ld_valid, ld_addr, ld_data, mem_rdata,
        input  fetch_valid, fetch_instr, fetch_pc_out, ld_ready,
        input  mem_addr, mem_we, mem_wdata, busy
    );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Shares a single-port byte-wide instruction memory between the IF stage (4-byte
// little-endian reads over four cycles) and the program loader (byte writes).
module imem_fetch_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10,
    parameter int LD_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_fetch_arbiter_if.slave  bus
);
    localparam int              SW        = $clog2(LD_BURST + 1);
    localparam logic [SW-1:0]   BURST_MAX = SW'(LD_BURST);
    localparam logic [31:0]     ADDR_MASK = 32'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   buf_q, buf_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          ld_grant;
    logic          fetch_grant;
    logic [31:0]   rd_addr;
    logic          unused_bits;

    assign rd_addr     = (pc_q + {30'd0, cnt_q}) & ADDR_MASK;
    assign unused_bits = ^{rd_addr[31:ADDR_W], bus.ld_addr[31:ADDR_W]};

    // The streak limit only bites while a fetch is waiting; an idle IF stage
    // lets the loader stream without interruption.
    always_comb begin
        ld_grant    = 1'b0;
        fetch_grant = 1'b0;
        if (!reset && state_q == S_IDLE && !bus.flush) begin
            if (bus.ld_valid && streak_q < BURST_MAX) begin
                ld_grant = 1'b1;
            end else if (bus.fetch_req) begin
                fetch_grant = 1'b1;
            end else if (bus.ld_valid) begin
                ld_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_grant) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 2'd3) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.flush || bus.fetch_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        if (fetch_grant) begin
            pc_d  = bus.fetch_pc;
            cnt_d = 2'd0;
        end else if (state_q == S_RD) begin
            cnt_d = cnt_q + 2'd1;
        end
        if (!bus.fetch_req || fetch_grant) begin
            streak_d = '0;
        end else if (ld_grant) begin
            streak_d = streak_q + SW'(1);
        end
    end

    // One byte lane per read cycle; a new grant wipes all lanes so no byte of
    // an earlier or aborted fetch can leak into the next instruction.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign buf_d[8*gi +: 8] = fetch_grant ? 8'h00 :
                                      (state_q == S_RD && cnt_q == 2'(gi)) ? bus.mem_rdata :
                                      buf_q[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            streak_q <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        bus.ld_ready     = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = 8'h00;
        bus.fetch_valid  = 1'b0;
        bus.fetch_instr  = 32'h0;
        bus.busy         = 1'b0;
        bus.fetch_pc_out = pc_q;
        if (ld_grant) begin
            bus.ld_ready  = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr[ADDR_W-1:0];
            bus.mem_wdata = bus.ld_data;
        end
        unique case (state_q)
            S_RD: begin
                bus.mem_addr = rd_addr[ADDR_W-1:0];
                bus.busy     = 1'b1;
            end
            S_HOLD: begin
                bus.fetch_valid = 1'b1;
                bus.fetch_instr = buf_q;
                bus.busy        = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed scenarios plus random traffic, checked each
// cycle against a phase-counting transaction model and a shadow byte image.
module tb_imem_fetch_arbiter;
    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;
    localparam int LD_BURST  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_fetch_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    imem_fetch_arbiter #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W(ADDR_W),
        .LD_BURST(LD_BURST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Memory array attached to the DUT: combinational read, synchronous byte write.
    logic [7:0]        env_mem [MEM_BYTES];
    logic              fill_en = 1'b1;
    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [7:0]        poke_data = 8'h00;

    function automatic logic [7:0] fill_byte(input int i);
        return 8'((i * 13 + 7) & 255);
    endfunction

    assign bus.mem_rdata = env_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < MEM_BYTES; i++) env_mem[i] <= fill_byte(i);
        end else if (poke_en) begin
            env_mem[poke_addr] <= poke_data;
        end else if (bus.mem_we) begin
            env_mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: shadow memory image plus a fetch phase counter
    // (0 idle, 1..4 reading byte phase-1, 5 presenting).
    logic [7:0]  ref_mem [MEM_BYTES];
    int          m_phase  = 0;
    int          m_streak = 0;
    logic [31:0] m_pc     = '0;
    logic [31:0] m_pc_out = '0;
    logic [31:0] m_instr  = '0;
    int          hs_cnt   = 0;
    int          obs_hs   = 0;
    bit          chk_en   = 1'b0;

    function automatic logic [31:0] ref_word(input logic [31:0] pc);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = ref_mem[ADDR_W'((pc + 32'(k)) % 32'(MEM_BYTES))];
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = fill_byte(i);
    end

    initial begin : model
        bit                ldg;
        bit                fg;
        logic [ADDR_W-1:0] e_addr;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ldg = 1'b0;
                fg  = 1'b0;
                if (!reset && m_phase == 0 && !bus.flush) begin
                    if (bus.ld_valid && m_streak < LD_BURST) ldg = 1'b1;
                    else if (bus.fetch_req)                  fg  = 1'b1;
                    else if (bus.ld_valid)                   ldg = 1'b1;
                end
                e_addr = ldg ? bus.ld_addr[ADDR_W-1:0] : '0;
                if (m_phase >= 1 && m_phase <= 4) begin
                    e_addr = ADDR_W'((m_pc + 32'(m_phase - 1)) % 32'(MEM_BYTES));
                end
                chk1("ld_ready", bus.ld_ready, ldg);
                chk1("mem_we", bus.mem_we, ldg);
                chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
                if (ldg) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.ld_data));
                chk1("fetch_valid", bus.fetch_valid, m_phase == 5);
                if (m_phase == 5) chk("fetch_instr", bus.fetch_instr, m_instr);
                chk("fetch_pc_out", bus.fetch_pc_out, m_pc_out);
                chk1("busy", bus.busy, m_phase != 0);
                if (bus.fetch_valid && bus.fetch_ready && !bus.flush) obs_hs++;

                if (reset) begin
                    m_phase  = 0;
                    m_streak = 0;
                    m_pc_out = '0;
                end else begin
                    if (ldg) begin
                        ref_mem[bus.ld_addr[ADDR_W-1:0]] = bus.ld_data;
                        $display("load addr=%03h data=%02h", bus.ld_addr[ADDR_W-1:0], bus.ld_data);
                    end
                    case (m_phase)
                        0: if (fg) begin
                            m_phase  = 1;
                            m_pc     = bus.fetch_pc;
                            m_pc_out = bus.fetch_pc;
                            m_instr  = ref_word(bus.fetch_pc);
                        end
                        1, 2, 3, 4: m_phase = bus.flush ? 0 : m_phase + 1;
                        default: begin
                            if (bus.flush) begin
                                m_phase = 0;
                            end else if (bus.fetch_ready) begin
                                m_phase = 0;
                                hs_cnt++;
                                $display("fetch pc=%08h instr=%08h", m_pc_out, m_instr);
                            end
                        end
                    endcase
                    if (!bus.fetch_req || fg) m_streak = 0;
                    else if (ldg)             m_streak = m_streak + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        tick();
        poke_en   = 1'b1;
        poke_addr = ADDR_W'(a);
        poke_data = d;
        ref_mem[a] = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic rdy,
                         output logic [31:0] instr, output int lat);
        tick();
        bus.fetch_req   = 1'b1;
        bus.fetch_pc    = pc;
        bus.fetch_ready = rdy;
        @(negedge clk);
        lat = 0;
        while (lat < 20) begin
            tick();
            bus.fetch_req = 1'b0;
            @(negedge clk);
            lat++;
            if (bus.fetch_valid) break;
        end
        chk1("fetch_seen", bus.fetch_valid, 1'b1);
        instr = bus.fetch_instr;
    endtask

    task automatic ld_write(input logic [31:0] a, input logic [7:0] d);
        int n;
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.ld_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("ld_accept", bus.ld_ready, 1'b1);
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk1({tag, "_valid"}, bus.fetch_valid, 1'b0);
        chk({tag, "_instr"}, bus.fetch_instr, 32'h0);
        chk({tag, "_pc_out"}, bus.fetch_pc_out, 32'h0);
        chk1({tag, "_we"}, bus.mem_we, 1'b0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'h0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
        chk1({tag, "_ld_ready"}, bus.ld_ready, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] instr;
        int          lat;
        int          hs_before;
        logic [10:0] ld_pat;
        logic [10:0] busy_pat;

        bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.fetch_ready = 1'b0; bus.flush = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = 8'h00;

        @(posedge clk);
        #1;
        fill_en = 1'b0;
        chk_en  = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Plain aligned fetch
        poke(0, 8'h33); poke(1, 8'h84); poke(2, 8'hA2); poke(3, 8'h00);
        fetch(32'h0, 1'b1, instr, lat);
        chk("t1_latency", 32'(lat), 32'd5);
        chk("t1_instr", instr, 32'h00A28433);
        chk("t1_model", m_instr, 32'h00A28433);
        chk("t1_pc_out", bus.fetch_pc_out, 32'h0);
        tick();
        @(negedge clk);
        chk1("t1_valid_drop", bus.fetch_valid, 1'b0);

        // Misaligned fetch wrapping past the top of memory
        poke(1023, 8'h11); poke(0, 8'h22); poke(1, 8'h33); poke(2, 8'h44);
        fetch(32'h3FF, 1'b1, instr, lat);
        chk("t2_instr", instr, 32'h44332211);
        chk("t2_pc_out", bus.fetch_pc_out, 32'h3FF);

        // Stall in HOLD, then flush together with fetch_ready
        poke(3, 8'h55);
        fetch(32'h0, 1'b0, instr, lat);
        chk("t3_instr", instr, 32'h55443322);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk1("t3_stall_valid", bus.fetch_valid, 1'b1);
            chk("t3_stall_instr", bus.fetch_instr, 32'h55443322);
        end
        hs_before = obs_hs;
        tick();
        bus.flush = 1'b1;
        bus.fetch_ready = 1'b1;
        @(negedge clk);
        tick();
        bus.flush = 1'b0;
        bus.fetch_ready = 1'b0;
        @(negedge clk);
        chk1("t3_flush_valid", bus.fetch_valid, 1'b0);
        chk1("t3_flush_busy", bus.busy, 1'b0);
        chk("t3_no_handshake", 32'(obs_hs), 32'(hs_before));

        // Loader and fetch competing: four writes, one fetch, loader again
        tick();
        bus.ld_valid = 1'b1; bus.ld_addr = 32'd300; bus.ld_data = 8'h5A;
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'd0; bus.fetch_ready = 1'b1;
        ld_pat = '0;
        busy_pat = '0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ld_pat[i]   = bus.ld_ready;
            busy_pat[i] = bus.busy;
            if (i < 10) begin
                tick();
                bus.ld_data = 8'(i + 1);
            end
        end
        tick();
        bus.ld_valid = 1'b0;
        bus.fetch_req = 1'b0;
        chk("t4_ld_pattern", 32'(ld_pat), 32'h40F);
        chk("t4_busy_pattern", 32'(busy_pat), 32'h3E0);

        // Loader writes observed by the following fetch
        ld_write(32'd12, 8'h5B);
        ld_write(32'd13, 8'hFD);
        ld_write(32'd14, 8'h93);
        ld_write(32'd15, 8'h00);
        fetch(32'd12, 1'b1, instr, lat);
        chk("t5_instr", instr, 32'h0093FD5B);
        chk("t5_model", m_instr, 32'h0093FD5B);

        // Reset in the middle of a fetch (cnt == 2)
        poke(4, 8'hEF); poke(5, 8'hBE); poke(6, 8'hAD); poke(7, 8'hDE);
        tick();
        bus.fetch_req = 1'b1; bus.fetch_pc = 32'd0; bus.fetch_ready = 1'b1;
        @(negedge clk);
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_cnt2_addr", 32'(bus.mem_addr), 32'd2);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("t6_rst");
        fetch(32'd4, 1'b1, instr, lat);
        chk("t6_instr", instr, 32'hDEADBEEF);
        chk("t6_latency", 32'(lat), 32'd5);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset           = ($urandom_range(0, 299) == 0);
            bus.flush       = ($urandom_range(0, 15) == 0);
            bus.fetch_req   = ($urandom_range(0, 2) != 0);
            bus.fetch_pc    = $urandom;
            bus.fetch_ready = ($urandom_range(0, 3) != 0);
            bus.ld_valid    = 1'($urandom_range(0, 1));
            bus.ld_addr     = $urandom;
            bus.ld_data     = 8'($urandom);
        end
        tick();
        reset = 1'b0; bus.flush = 1'b0; bus.fetch_req = 1'b0; bus.ld_valid = 1'b0;
        bus.fetch_ready = 1'b1;
        repeat (8) tick();
        chk("handshake_count", 32'(obs_hs), 32'(hs_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
